// File: rtl/stream_pkg.sv
// Shared definitions for valid/ready stream cores: slice state encoding and
// the saturating-counter helper.
package stream_pkg;

    // The state encoding doubles as the out_valid value.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slice_state_t;

    localparam int CNT_EXT_W = 64;

    // Saturating increment. Narrower counters pass their value with all bits
    // above their own width set to one, so "all ones" here means "all ones"
    // at the caller's width and the truncated result never wraps.
    function automatic logic [CNT_EXT_W-1:0] counter_next(
        input logic [CNT_EXT_W-1:0] cnt,
        input logic                 inc
    );
        if (inc && (cnt != {CNT_EXT_W{1'b1}})) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/saturating_counter.sv
// Up-counter that sticks at all-ones; cleared only by reset.
module saturating_counter
    import stream_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [CNT_EXT_W-1:0] count_ext;
    logic [WIDTH-1:0]     count_d;

    // Pad the upper bits with ones so the shared helper saturates at WIDTH.
    always_comb begin
        count_ext              = {CNT_EXT_W{1'b1}};
        count_ext[WIDTH-1:0]   = count;
        count_d                = WIDTH'(counter_next(count_ext, inc));
    end

    // Count register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

endmodule

// File: rtl/forward_register_slice.sv
// Valid/ready stage with registered out_valid/out_data, synchronous flush and
// saturating beat/stall debug counters.
//
//   state | meaning
//   ------+--------------------------------------------------
//   EMPTY | no beat held, out_valid=0
//   FULL  | beat held in out_data, out_valid=1
module forward_register_slice
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] beat_count,
    output logic [COUNT_WIDTH-1:0] stall_count
);

    slice_state_t state_q;
    slice_state_t state_d;
    logic         load;
    logic         in_hs;
    logic         out_hs;
    logic         stall;

    assign out_valid = (state_q == FULL);
    // Ready is deliberately combinational from out_ready so a FULL slice can
    // accept a new beat in the same cycle its held beat drains.
    assign in_ready  = resetn && !flush && ((state_q == EMPTY) || out_ready);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign stall     = out_valid && !out_ready;

    // Next-state and load decision; flush overrides everything.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_hs) begin
                        state_d = FULL;
                        load    = 1'b1;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            load = 1'b1;
                        end else begin
                            state_d = EMPTY;
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State register; its value is out_valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload register; holds while stalled or empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_data <= '0;
        end else if (load) begin
            out_data <= in_data;
        end
    end

    saturating_counter #(.WIDTH(COUNT_WIDTH)) u_beat_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (out_hs),
        .count  (beat_count)
    );

    saturating_counter #(.WIDTH(COUNT_WIDTH)) u_stall_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (stall),
        .count  (stall_count)
    );

`ifdef FORMAL
    logic past_valid;

    // Guards $past until one clock has elapsed out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            past_valid <= 1'b0;
        end else begin
            past_valid <= 1'b1;
        end
    end

    a_stall_stable: assert property (@(posedge clk) disable iff (!resetn)
        past_valid && $past(stall && !flush) |-> out_valid && (out_data == $past(out_data)));

    a_valid_is_next_state: assert property (@(posedge clk) disable iff (!resetn)
        past_valid |-> out_valid == ($past(state_d) == FULL));

    a_beat_monotonic: assert property (@(posedge clk) disable iff (!resetn)
        past_valid |-> beat_count >= $past(beat_count));

    a_stall_monotonic: assert property (@(posedge clk) disable iff (!resetn)
        past_valid |-> stall_count >= $past(stall_count));
`endif

endmodule

// File: doc/forward_register_slice.md
Name: forward_register_slice

Overview:
- Valid/ready pipeline stage that registers the forward path: out_valid and out_data come from flops.
- Complements the team's skid buffer, which registers the backward ready path. Chaining the two gives a fully registered AXI/AXI-Stream channel.
- Sits between any valid/ready producer and consumer in the example cores.
- Includes a synchronous flush and saturating debug counters for handshakes and stalls.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- COUNT_WIDTH, 16, width of the beat_count and stall_count outputs.

Ports:
- clk  input  1  single clock; all logic is on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; discards any held beat.
- in_data  input  DATA_WIDTH  upstream payload.
- in_valid  input  1  upstream valid.
- in_ready  output  1  upstream ready (combinational).
- out_data  output  DATA_WIDTH  registered payload.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.
- beat_count  output  COUNT_WIDTH  number of output handshakes, saturating.
- stall_count  output  COUNT_WIDTH  number of cycles with out_valid && !out_ready, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset resetn is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, beat_count=0, stall_count=0, state=EMPTY. While resetn=0, in_ready=0.
- States:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - The state is exactly the out_valid flop; there is no other state.
- in_ready = resetn && !flush && (state==EMPTY || out_ready). This is combinational from out_ready, which is intentional.
- Input handshake: in_hs = in_valid && in_ready. Output handshake: out_hs = out_valid && out_ready.
- Transitions (flush has highest priority):
  - flush=1: next state EMPTY, out_data unchanged, no load. An out_hs in that cycle still counts as a beat.
  - EMPTY, in_hs: go to FULL, out_data <= in_data.
  - EMPTY, !in_valid: stay EMPTY.
  - FULL, out_ready && in_valid: stay FULL, out_data <= in_data. This is the back-to-back case with no bubble.
  - FULL, out_ready && !in_valid: go to EMPTY.
  - FULL, !out_ready: stay FULL. out_data and out_valid must hold stable until out_hs (AXI stability rule).
- Latency and throughput:
  - Exactly 1 cycle from in_hs to out_valid.
  - Sustains 1 beat per cycle while out_ready=1.
- Counters:
  - beat_count increments on out_hs. stall_count increments on out_valid && !out_ready.
  - Both saturate at all-ones and never wrap. Both are cleared only by reset, not by flush.
- Boundaries:
  - in_valid deasserted before a handshake: no load occurs; the slice does not police upstream protocol.
  - Reset asserted mid-transfer: the held beat is lost, and out_valid drops asynchronously.
  - Reset deassertion: in_ready rises in the same cycle, combinationally.
- out_data when EMPTY: holds its last value and is don't-care to consumers.

Decomposition:
- Shared package stream_pkg:
  - EMPTY/FULL state localparams.
  - a function counter_next(cnt, inc) returning the saturating increment, reused by future cores.
- One natural sub-module: saturating_counter (parameter WIDTH; ports clk, resetn, inc, count), instantiated twice.
- Formal properties go under the team's existing past_valid guard:
  - stability while stalled;
  - out_valid == $past(state next);
  - counters monotonic.

Test Plan:
- Reset then idle: resetn 0->1 with in_valid=0 -> out_valid=0, in_ready=1, beat_count=0.
- Single beat: in_data=0xDEADBEEF, in_valid=1 for 1 cycle, out_ready=1 -> out_valid=1 with 0xDEADBEEF on the next cycle, then 0; beat_count=1.
- Streaming: 8 beats, values 1..8, one per cycle, out_ready=1 -> outputs 1..8 in consecutive cycles, no bubble; beat_count=8.
- Backpressure: beat 0xA5 held while out_ready=0 for 5 cycles with in_valid=1 and in_data=0x5A -> out_data stays 0xA5, in_ready=0, stall_count=5. After out_ready=1, 0x5A follows with no loss.
- Flush: FULL with 0x11, flush=1 for one cycle, out_ready=0 -> next cycle out_valid=0, in_ready=0 during the flush cycle, beat_count unchanged.
- Saturation and async reset: COUNT_WIDTH=4 with 20 beats -> beat_count=15. Then resetn pulsed low mid-cycle -> out_valid=0 before the next clk edge, counters=0.
